tcb_lib_ndn_responder: RTL
==========================

TCB_LIB_NDN_RESPONDER -- requirements
Module: tcb_lib_ndn_responder

Interface
REQ-001 Parameter NDN, default 2'd0, bus endianness mode: 0=DEFAULT, 1=BI_NDN, 2=LITTLE, 3=BIG.
REQ-002 Parameter ORD, default 1'b0, native byte order used in DEFAULT mode (0=little, 1=big).
REQ-003 Parameter DLY, default 1, fixed response delay in cycles, legal range 1..4.
REQ-004 Parameter DEP, default 16, storage depth in 32-bit words.
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 tcb_vld  input  1  request valid.
REQ-008 tcb_rdy  output  1  request ready.
REQ-009 tcb_wen  input  1  write enable (1=write, 0=read).
REQ-010 tcb_adr  input  8  byte address.
REQ-011 tcb_ben  input  4  byte enables, in transaction lane order.
REQ-012 tcb_wdt  input  32  write data, in transaction lane order.
REQ-013 tcb_ndn  input  1  requested transaction endianness (0=little, 1=big).
REQ-014 tcb_rsp_vld  output  1  response valid strobe.
REQ-015 tcb_rdt  output  32  read data, in transaction lane order.
REQ-016 tcb_err  output  1  response error status.

Function
REQ-017 tcb_rdy SHALL be constantly 1 while rst is low; transfer = tcb_vld & tcb_rdy.
REQ-018 Effective endianness: DEFAULT -> ORD; BI_NDN -> tcb_ndn; LITTLE -> 0; BIG -> 1.
REQ-019 Endianness error: in DEFAULT, LITTLE and BIG modes, tcb_ndn differing from effective endianness SHALL flag an error.
REQ-020 Alignment error: tcb_adr[1:0] != 0 SHALL flag an error.
REQ-021 Range error: tcb_adr[7:2] >= DEP SHALL flag an error.
REQ-022 Storage SHALL hold bytes in little-endian lane order; word index = tcb_adr[7:2].
REQ-023 Big-endian transfer: transaction lane i SHALL map to storage lane 3-i for ben, wdt and rdt. Little-endian transfer: identity mapping.
REQ-024 Errored transfer: no storage update; response tcb_err=1, tcb_rdt=0.
REQ-025 Write transfer: enabled bytes (after lane mapping) SHALL be committed at the transfer clock edge; response tcb_rdt=0.
REQ-026 Read transfer: storage SHALL be read in the transfer cycle; tcb_rdt SHALL hold all 4 bytes regardless of tcb_ben.
REQ-027 Write and read ordering: a read in cycle N+1 SHALL observe a write transferred in cycle N.
REQ-028 Latency: a transfer in cycle N SHALL produce tcb_rsp_vld=1 with tcb_rdt/tcb_err in cycle N+DLY; implemented as a DLY-deep shift pipeline.
REQ-029 Back-to-back transfers SHALL be accepted every cycle and produce one response each, in order, with no bubbles.
REQ-030 When tcb_rsp_vld=0, tcb_rdt and tcb_err SHALL be 0.

Reset
REQ-031 While rst is high: tcb_rdy=0, tcb_rsp_vld=0, tcb_rdt=0, tcb_err=0, all pipeline stages cleared, all storage bytes cleared to 0.
REQ-032 Assertion of rst mid-operation SHALL discard all in-flight responses; none SHALL appear after rst deasserts.
REQ-033 The first transfer SHALL be accepted on the first rising edge with rst low.

Verification
REQ-034 NDN=1, DLY=1: write adr=0x04, ndn=0, ben=4'hF, wdt=32'h11223344; then read adr=0x04, ndn=1 -> read response rdt=32'h44332211, err=0, one cycle after the read.
REQ-035 NDN=1: write adr=0x08, ndn=1, ben=4'b0001, wdt=32'h000000AA after reset; then read ndn=0 -> rdt=32'hAA000000.
REQ-036 NDN=0, ORD=0: write ndn=1 to adr=0x00 -> err=1, rdt=0; subsequent read of adr=0x00 returns 0, err=0.
REQ-037 Read adr=0x02 -> err=1. Read adr=0x40 with DEP=16 -> err=1. Storage unchanged in both cases.
REQ-038 DLY=3: 5 back-to-back reads -> 5 consecutive tcb_rsp_vld cycles, starting 3 cycles after the first transfer, in request order.
REQ-039 DLY=2: assert rst one cycle after a read transfer -> no tcb_rsp_vld after rst deasserts, and every storage word reads 0.

Source files
------------

// File: rtl/tcb_lib_ndn_responder.sv
// TCB memory responder with configurable bus endianness and byte-lane swapping.
// Latency: response appears DLY cycles after the transfer, through a DLY-deep shift pipeline.
// Backpressure: none; ready is high whenever reset is low, so every valid request transfers.
module tcb_lib_ndn_responder #(
  parameter logic [1:0] NDN = 2'd0,
  parameter logic       ORD = 1'b0,
  parameter int         DLY = 1,
  parameter int         DEP = 16
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        tcb_vld,
  output logic        tcb_rdy,
  input  logic        tcb_wen,
  input  logic [7:0]  tcb_adr,
  input  logic [3:0]  tcb_ben,
  input  logic [31:0] tcb_wdt,
  input  logic        tcb_ndn,
  output logic        tcb_rsp_vld,
  output logic [31:0] tcb_rdt,
  output logic        tcb_err
);

  localparam int         AW    = (DEP > 1) ? $clog2(DEP) : 1;
  localparam logic [6:0] DEP_L = 7'(DEP);

  logic          trn;
  logic          ndn_eff;
  logic          err_ndn;
  logic          err_aln;
  logic          err_rng;
  logic          err_any;
  logic [AW-1:0] widx;
  logic [3:0]    ben_s;
  logic [31:0]   wdt_s;
  logic [31:0]   rd_word;
  logic [31:0]   rdt_t;

  // storage in little-endian lane order: byte 0 of a word lives in bits [7:0]
  logic [31:0] mem [DEP];

  // response pipeline; stage DLY-1 drives the outputs
  logic        pipe_vld [DLY];
  logic [31:0] pipe_rdt [DLY];
  logic        pipe_err [DLY];

  assign tcb_rdy = ~rst;
  assign trn     = tcb_vld & tcb_rdy;
  assign widx    = tcb_adr[AW+1:2];
  assign rd_word = mem[widx];

  // decode effective endianness and the three error sources
  always_comb begin
    ndn_eff = 1'b0;
    case (NDN)
      2'd0:    ndn_eff = ORD;
      2'd1:    ndn_eff = tcb_ndn;
      2'd2:    ndn_eff = 1'b0;
      default: ndn_eff = 1'b1;
    endcase
    // in bi-endian mode the request chooses the order, so it can never disagree
    err_ndn = (NDN != 2'd1) && (tcb_ndn != ndn_eff);
    err_aln = |tcb_adr[1:0];
    err_rng = ({1'b0, tcb_adr[7:2]} >= DEP_L);
    err_any = err_ndn | err_aln | err_rng;
  end

  // map transaction lanes to storage lanes (byte reversal for big-endian transfers)
  always_comb begin
    ben_s = tcb_ben;
    wdt_s = tcb_wdt;
    rdt_t = rd_word;
    if (ndn_eff) begin
      for (int i = 0; i < 4; i++) begin
        ben_s[3-i]         = tcb_ben[i];
        wdt_s[8*(3-i) +: 8] = tcb_wdt[8*i +: 8];
        rdt_t[8*(3-i) +: 8] = rd_word[8*i +: 8];
      end
    end
  end

  // byte-enabled write commit at the transfer edge; reset clears every word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < DEP; w++) mem[w] <= '0;
    end else if (trn && tcb_wen && !err_any) begin
      for (int b = 0; b < 4; b++) begin
        if (ben_s[b]) mem[widx][8*b +: 8] <= wdt_s[8*b +: 8];
      end
    end
  end

  // response shift pipeline; data and error are zero unless the stage holds a response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DLY; s++) begin
        pipe_vld[s] <= 1'b0;
        pipe_rdt[s] <= '0;
        pipe_err[s] <= 1'b0;
      end
    end else begin
      pipe_vld[0] <= trn;
      pipe_err[0] <= trn & err_any;
      pipe_rdt[0] <= (trn && !tcb_wen && !err_any) ? rdt_t : 32'h0;
      for (int s = 1; s < DLY; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_rdt[s] <= pipe_rdt[s-1];
        pipe_err[s] <= pipe_err[s-1];
      end
    end
  end

  assign tcb_rsp_vld = pipe_vld[DLY-1];
  assign tcb_rdt     = pipe_rdt[DLY-1];
  assign tcb_err     = pipe_err[DLY-1];

endmodule
